// File: rtl/hazard_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_control_unit_pkg
// Shared definitions for the pipeline hazard sequencer:
//   - state_t        : watchdog FSM encoding (RUN / MEM_WAIT)
//   - ctrl_t         : bundle of the seven pipeline control outputs
//   - CTRL_*         : control patterns for each hazard resolution
//   - WAIT_W         : width of the memory-wait watchdog counter
//   - MEM_TIMEOUT_DEFAULT : default watchdog limit
// -----------------------------------------------------------------------------
package hazard_control_unit_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  // Watchdog limit is bounded to 1..2^16-1, so 16 bits always suffice.
  localparam int WAIT_W              = 16;
  localparam int MEM_TIMEOUT_DEFAULT = 255;

  // Bit order (MSB..LSB) is fixed so patterns can be written as literals.
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_PASS     = 7'b1101010; // normal advance
  localparam ctrl_t CTRL_RESET    = 7'b0010101; // hold everything, NOP all stages
  localparam ctrl_t CTRL_MEM_WAIT = 7'b0000001; // freeze front end, bubble into WB
  localparam ctrl_t CTRL_BRANCH   = 7'b1111110; // squash wrong-path IF/ID and ID/EX
  localparam ctrl_t CTRL_LOAD_USE = 7'b0001110; // hold PC/IF/ID, bubble into EX

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that increments by one when i_inc is high and sticks at
// all-ones instead of wrapping.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, clears the count
//   i_inc   : count this cycle
//   o_count : current count value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
// Pipeline sequencer for the 5-stage RV32I core. Resolves the hazards that
// forwarding cannot: load-use (one bubble), taken branch/jump in EX (flush
// IF/ID and ID/EX) and data-memory wait (full freeze with a watchdog).
// Priority is mem_wait > branch > load_use; a losing event is simply held in
// place by the freeze and re-evaluated on the next cycle.
// Ports:
//   clk, rst_n                      : clock / async active-low reset
//   ID_read_register_0/1            : rs1/rs2 of the ID instruction
//   ID_uses_rs_0/1                  : ID instruction actually reads rs1/rs2
//   EX_mem_read                     : EX instruction is a load
//   EX_destination_register         : rd of the EX instruction
//   EX_branch_taken                 : branch/jump resolved taken in EX
//   MEM_mem_access, MEM_mem_ready   : data-memory handshake in MEM
//   pc_write_enable .. MEM_WB_flush : pipeline register controls (combinational)
//   mem_timeout_error               : sticky watchdog flag
//   stall_count, flush_count,
//   mem_wait_count                  : saturating event counters
// -----------------------------------------------------------------------------
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           ID_read_register_0,
  input  logic [4:0]           ID_read_register_1,
  input  logic                 ID_uses_rs_0,
  input  logic                 ID_uses_rs_1,
  input  logic                 EX_mem_read,
  input  logic [4:0]           EX_destination_register,
  input  logic                 EX_branch_taken,
  input  logic                 MEM_mem_access,
  input  logic                 MEM_mem_ready,
  output logic                 pc_write_enable,
  output logic                 IF_ID_write_enable,
  output logic                 IF_ID_flush,
  output logic                 ID_EX_write_enable,
  output logic                 ID_EX_flush,
  output logic                 EX_MEM_write_enable,
  output logic                 MEM_WB_flush,
  output logic                 mem_timeout_error,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic [CNT_WIDTH-1:0] mem_wait_count
);

  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic w_mem_wait;
  logic w_branch;
  logic w_rs0_hit;
  logic w_rs1_hit;
  logic w_load_use;
  logic w_branch_win;
  logic w_stall_win;

  assign w_mem_wait = MEM_mem_access && !MEM_mem_ready;
  assign w_branch   = EX_branch_taken;
  assign w_rs0_hit  = ID_uses_rs_0 && (ID_read_register_0 == EX_destination_register);
  assign w_rs1_hit  = ID_uses_rs_1 && (ID_read_register_1 == EX_destination_register);
  // x0 is hardwired to zero, so a load "writing" it never creates a dependency.
  assign w_load_use = EX_mem_read && (EX_destination_register != 5'd0)
                      && (w_rs0_hit || w_rs1_hit);

  assign w_branch_win = w_branch && !w_mem_wait;
  assign w_stall_win  = w_load_use && !w_mem_wait && !w_branch;

  // ---------------------------------------------------------------------------
  // Watchdog FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_next;
  logic              r_error;
  ctrl_t             w_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_mem_wait) begin
          w_state_next = ST_MEM_WAIT;
          w_wait_next  = WAIT_ONE;
        end else begin
          w_wait_next  = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (!w_mem_wait) begin
          w_state_next = ST_RUN;
          w_wait_next  = '0;
        end else if (r_wait_cnt != TIMEOUT_V) begin
          w_wait_next  = r_wait_cnt + WAIT_ONE;
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_wait_next  = '0;
      end
    endcase
  end

  // The error is raised on the edge where the wait count reaches the limit
  // while memory is still stalled; it then holds until reset. It does not
  // abort the freeze: the pipeline stays frozen for as long as memory stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_error    <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_next;
      if (w_mem_wait && (w_wait_next == TIMEOUT_V)) begin
        r_error <= 1'b1;
      end
    end
  end

  // Controls are a zero-latency function of the current hazards; reset
  // overrides everything so no stage captures garbage while held.
  always_comb begin
    w_ctrl = CTRL_PASS;
    if (!rst_n) begin
      w_ctrl = CTRL_RESET;
    end else if (w_mem_wait) begin
      w_ctrl = CTRL_MEM_WAIT;
    end else if (w_branch) begin
      w_ctrl = CTRL_BRANCH;
    end else if (w_load_use) begin
      w_ctrl = CTRL_LOAD_USE;
    end
  end

  assign pc_write_enable     = w_ctrl.pc_we;
  assign IF_ID_write_enable  = w_ctrl.if_id_we;
  assign IF_ID_flush         = w_ctrl.if_id_flush;
  assign ID_EX_write_enable  = w_ctrl.id_ex_we;
  assign ID_EX_flush         = w_ctrl.id_ex_flush;
  assign EX_MEM_write_enable = w_ctrl.ex_mem_we;
  assign MEM_WB_flush        = w_ctrl.mem_wb_flush;
  assign mem_timeout_error   = r_error;

  // ---------------------------------------------------------------------------
  // Event counters: stall, flush, memory-wait
  // ---------------------------------------------------------------------------
  logic [2:0]           w_inc;
  logic [CNT_WIDTH-1:0] w_count [3];

  assign w_inc = {w_mem_wait, w_branch_win, w_stall_win};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_evt_cnt
      sat_counter #(
        .WIDTH (CNT_WIDTH)
      ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_inc[gi]),
        .o_count (w_count[gi])
      );
    end
  endgenerate

  assign stall_count    = w_count[0];
  assign flush_count    = w_count[1];
  assign mem_wait_count = w_count[2];

endmodule

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
// Directed vector table for the single-cycle hazard decode plus hand-written
// sequences for memory freeze, watchdog timeout and mid-wait reset.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs0, rs1, ex_rd;
  logic        use0, use1, ex_mr, ex_br, m_acc, m_rdy;
  logic        pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, memwb_fl;
  logic        err;
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  int exp_wait  = 0;

  localparam logic [6:0] C_PASS   = 7'b1101010;
  localparam logic [6:0] C_RESET  = 7'b0010101;
  localparam logic [6:0] C_MWAIT  = 7'b0000001;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_LDUSE  = 7'b0001110;

  hazard_control_unit #(
    .CNT_WIDTH   (32),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .ID_read_register_0      (rs0),
    .ID_read_register_1      (rs1),
    .ID_uses_rs_0            (use0),
    .ID_uses_rs_1            (use1),
    .EX_mem_read             (ex_mr),
    .EX_destination_register (ex_rd),
    .EX_branch_taken         (ex_br),
    .MEM_mem_access          (m_acc),
    .MEM_mem_ready           (m_rdy),
    .pc_write_enable         (pc_we),
    .IF_ID_write_enable      (ifid_we),
    .IF_ID_flush             (ifid_fl),
    .ID_EX_write_enable      (idex_we),
    .ID_EX_flush             (idex_fl),
    .EX_MEM_write_enable     (exmem_we),
    .MEM_WB_flush            (memwb_fl),
    .mem_timeout_error       (err),
    .stall_count             (stall_cnt),
    .flush_count             (flush_cnt),
    .mem_wait_count          (wait_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs0, rs1;
    logic       u0, u1, mr;
    logic [4:0] rd;
    logic       br, acc, rdy;
    logic [6:0] ctrl;
    int         d_stall, d_flush, d_wait;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(string name, logic [4:0] r0, logic [4:0] r1,
                              logic u0, logic u1, logic mr, logic [4:0] rd,
                              logic br, logic acc, logic rdy, logic [6:0] ctrl,
                              int ds, int df, int dw);
    vec_t v;
    v.name = name; v.rs0 = r0; v.rs1 = r1; v.u0 = u0; v.u1 = u1; v.mr = mr;
    v.rd = rd; v.br = br; v.acc = acc; v.rdy = rdy; v.ctrl = ctrl;
    v.d_stall = ds; v.d_flush = df; v.d_wait = dw;
    return v;
  endfunction

  task automatic set_in(logic [4:0] r0, logic [4:0] r1, logic u0, logic u1,
                        logic mr, logic [4:0] rd, logic br, logic acc, logic rdy);
    rs0 = r0; rs1 = r1; use0 = u0; use1 = u1; ex_mr = mr; ex_rd = rd;
    ex_br = br; m_acc = acc; m_rdy = rdy;
  endtask

  task automatic set_idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_ctrl(string name, logic [6:0] exp);
    logic [6:0] act;
    act = {pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, memwb_fl};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ctrl got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_counts(string name);
    checks++;
    if (stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush) ||
        wait_cnt !== 32'(exp_wait)) begin
      errors++;
      $display("FAIL %s counts got stall=%0d flush=%0d wait=%0d want stall=%0d flush=%0d wait=%0d",
               name, stall_cnt, flush_cnt, wait_cnt, exp_stall, exp_flush, exp_wait);
    end
  endtask

  task automatic check_err(string name, logic exp);
    checks++;
    if (err !== exp) begin
      errors++;
      $display("FAIL %s mem_timeout_error got %b want %b", name, err, exp);
    end
  endtask

  initial begin
    //           name           rs0  rs1  u0 u1 mr rd  br acc rdy ctrl      s f w
    vecs[0]  = mk("idle",        0,   0,  0, 0, 0, 0,  0, 0, 1, C_PASS,   0,0,0);
    vecs[1]  = mk("ld_x5_rs2",   3,   5,  1, 1, 1, 5,  0, 0, 1, C_LDUSE,  1,0,0);
    vecs[2]  = mk("ld_x0",       0,   0,  1, 1, 1, 0,  0, 0, 1, C_PASS,   0,0,0);
    vecs[3]  = mk("rs2_unused",  3,   5,  1, 0, 1, 5,  0, 0, 1, C_PASS,   0,0,0);
    vecs[4]  = mk("not_load",    5,   5,  1, 1, 0, 5,  0, 0, 1, C_PASS,   0,0,0);
    vecs[5]  = mk("ld_x7_rs1",   7,   2,  1, 1, 1, 7,  0, 0, 1, C_LDUSE,  1,0,0);
    vecs[6]  = mk("br_over_ld",  1,   5,  1, 1, 1, 5,  1, 0, 1, C_BRANCH, 0,1,0);
    vecs[7]  = mk("mwait",       0,   0,  0, 0, 0, 0,  0, 1, 0, C_MWAIT,  0,0,1);
    vecs[8]  = mk("mwait_all",   5,   5,  1, 1, 1, 5,  1, 1, 0, C_MWAIT,  0,0,1);
    vecs[9]  = mk("rdy_branch",  0,   0,  0, 0, 0, 0,  1, 1, 1, C_BRANCH, 0,1,0);
    vecs[10] = mk("back_to_run", 4,   9,  1, 1, 0, 9,  0, 0, 1, C_PASS,   0,0,0);

    // Reset state
    rst_n = 1'b0;
    set_idle();
    #2;
    check_ctrl("reset_ctrl", C_RESET);
    check_counts("reset_counts");
    check_err("reset_err", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_ctrl("post_reset", C_PASS);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i > 0) check_counts(vecs[i-1].name);
      set_in(vecs[i].rs0, vecs[i].rs1, vecs[i].u0, vecs[i].u1, vecs[i].mr,
             vecs[i].rd, vecs[i].br, vecs[i].acc, vecs[i].rdy);
      #1;
      check_ctrl(vecs[i].name, vecs[i].ctrl);
      exp_stall += vecs[i].d_stall;
      exp_flush += vecs[i].d_flush;
      exp_wait  += vecs[i].d_wait;
    end
    @(negedge clk);
    check_counts(vecs[10].name);
    check_err("no_err_after_table", 1'b0);

    // Three frozen cycles, then ready arrives together with a taken branch
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_ctrl("freeze3", C_MWAIT);
      @(negedge clk);
    end
    exp_wait += 3;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    #1;
    check_ctrl("ready_with_branch", C_BRANCH);
    exp_flush += 1;
    @(negedge clk);
    set_idle();
    check_counts("freeze3_counts");
    check_err("freeze3_no_err", 1'b0);

    // Watchdog: limit 4, memory stalls for 6 cycles
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      #1;
      check_ctrl("timeout_freeze", C_MWAIT);
      @(negedge clk);
      check_err("timeout_edge", (k >= 4) ? 1'b1 : 1'b0);
    end
    exp_wait += 6;
    set_idle();
    #1;
    check_ctrl("after_timeout_ready", C_PASS);
    @(negedge clk);
    check_err("timeout_sticky", 1'b1);
    check_counts("timeout_counts");

    // Reset asserted in the middle of a memory wait
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_stall = 0; exp_flush = 0; exp_wait = 0;
    check_ctrl("midwait_reset_ctrl", C_RESET);
    check_counts("midwait_reset_counts");
    check_err("midwait_reset_err", 1'b0);
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_ctrl("release_ctrl", C_PASS);
    set_in(5'd0, 5'd12, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b1);
    #1;
    check_ctrl("release_ld_use", C_LDUSE);
    exp_stall += 1;
    @(negedge clk);
    set_idle();
    check_counts("release_counts");
    check_err("release_err", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
